// File: rtl/ctrl_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_sequencer_pkg
//
// Shared types and sizing for the multi-channel control sequencer of the
// sample rate converter.
//
// Contents:
//   - sizing constants (vector ID, register file, data RAM, instruction
//     memory, channel count and per-channel data RAM stride)
//   - address / pointer / ID typedefs
//   - allocInstr_s   : one allocation instruction word
//   - fsmState_e     : 4-bit sequencer state (IDLE plus S1..S8)
//   - clamp_prog_len : limits a program length to the memory depth
// -----------------------------------------------------------------------------
package ctrl_sequencer_pkg;

    localparam int VECTOR_ID_WIDTH         = 4;
    localparam int REG_FILE_ADDRESS_WIDTH  = 5;
    localparam int DATA_RAM_ADDRESS_WIDTH  = 12;
    localparam int INSTRUCTION_MEMORY_SIZE = 32;
    localparam int NUM_CHANNELS            = 2;
    localparam int CH_STRIDE               = 1024;

    localparam int IP_WIDTH    = $clog2(INSTRUCTION_MEMORY_SIZE);
    // A single-channel build still needs a 1-bit channel field.
    localparam int CH_ID_WIDTH = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    typedef logic [DATA_RAM_ADDRESS_WIDTH-1:0] data_addr_t;
    typedef logic [REG_FILE_ADDRESS_WIDTH-1:0] reg_file_addr_t;
    typedef logic [VECTOR_ID_WIDTH-1:0]        vector_id_t;
    typedef logic [IP_WIDTH-1:0]               instr_pointer_t;
    typedef logic [IP_WIDTH:0]                 prog_len_t;
    typedef logic [CH_ID_WIDTH-1:0]            ch_id_t;

    typedef struct packed {
        data_addr_t     data_uptr;   // upper segment pointer (channel relative)
        data_addr_t     data_lptr;   // lower segment pointer (channel relative)
        data_addr_t     coef_ptr;    // coefficient pointer (shared by channels)
        vector_id_t     vector_id;
        reg_file_addr_t result_reg;  // always written after the convolution
        reg_file_addr_t error_reg;   // 0 = no error register write
        logic           lstg_f;      // last stage: produces an output sample
    } allocInstr_s;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        S1   = 4'd1,   // allocation (instruction fetch)
        S2   = 4'd2,   // MAC init
        S3   = 4'd3,   // convolution, wait for mac_done
        S4   = 4'd4,   // result register write
        S5   = 4'd5,   // error register write
        S6   = 4'd6,   // output sample strobe
        S7   = 4'd7,   // sample done, hand back to the audio bus
        S8   = 4'd8    // allocation list counter increment
    } fsmState_e;

    function automatic prog_len_t clamp_prog_len(input prog_len_t len);
        if (len > prog_len_t'(INSTRUCTION_MEMORY_SIZE)) begin
            return prog_len_t'(INSTRUCTION_MEMORY_SIZE);
        end
        return len;
    endfunction

endpackage

// File: rtl/ctrl_sequencer_instr_mem.sv
// -----------------------------------------------------------------------------
// ctrl_sequencer_instr_mem
//
// Allocation-instruction memory: one synchronous write port and one
// registered read port. The array itself has no reset; only the read data
// register is cleared so the sequencer outputs derived from it are 0 after
// reset.
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset (read register only)
//   i_we     in   write strobe
//   i_waddr  in   write address
//   i_wdata  in   instruction word to store
//   i_re     in   read enable; read register loads on the next clock edge
//   i_raddr  in   read address
//   o_rdata  out  registered read data
// -----------------------------------------------------------------------------
module ctrl_sequencer_instr_mem
    import ctrl_sequencer_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_we,
    input  instr_pointer_t i_waddr,
    input  allocInstr_s    i_wdata,
    input  logic           i_re,
    input  instr_pointer_t i_raddr,
    output allocInstr_s    o_rdata
);

    allocInstr_s r_mem [INSTRUCTION_MEMORY_SIZE];
    allocInstr_s r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// ctrl_sequencer
//
// Multi-channel control sequencer of the sample rate converter. For every
// accepted input sample it walks the loaded allocation program once, issuing
// MAC, register file and output strobes, with the data RAM segment pointers
// offset into the buffer of the sample's channel.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   iw_en/addr/data   instruction memory write port (dropped while busy)
//   prog_len          program length, 0 disables, clamped to memory depth
//   smp_valid, smp_ch sample offer from the audio bus and its channel
//   smp_ready         one-cycle pulse when the sample has been processed (S7)
//   mac_init          one-cycle pulse in S2
//   mac_start         pulse on the first S3 cycle
//   mac_done          MAC completion, may already be high on S3 entry
//   rf_we, rf_addr    register file write (result_reg in S4, error_reg in S5)
//   data_uptr/lptr    channel-offset data RAM segment pointers
//   coef_ptr          coefficient pointer (no channel offset)
//   vector_id         vector ID of the current instruction
//   out_valid         output sample strobe (S6)
//   state, busy       current state, state != IDLE
// -----------------------------------------------------------------------------
module ctrl_sequencer
    import ctrl_sequencer_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           iw_en,
    input  instr_pointer_t iw_addr,
    input  allocInstr_s    iw_data,
    input  prog_len_t      prog_len,
    input  logic           smp_valid,
    input  ch_id_t         smp_ch,
    output logic           smp_ready,
    output logic           mac_init,
    output logic           mac_start,
    input  logic           mac_done,
    output logic           rf_we,
    output reg_file_addr_t rf_addr,
    output data_addr_t     data_uptr,
    output data_addr_t     data_lptr,
    output data_addr_t     coef_ptr,
    output vector_id_t     vector_id,
    output logic           out_valid,
    output fsmState_e      state,
    output logic           busy
);

    fsmState_e      r_state;
    fsmState_e      w_next_state;
    instr_pointer_t r_ip;
    instr_pointer_t w_next_ip;
    prog_len_t      r_len;
    data_addr_t     r_ch_off;
    logic           r_s3_entry;

    allocInstr_s    w_instr;
    logic           w_ch_ok;
    logic           w_accept;
    logic           w_last;
    logic           w_mem_we;
    logic           w_mem_re;

    // Out-of-range channels are not accepted; the sample is left on the bus.
    assign w_ch_ok  = (int'(smp_ch) < NUM_CHANNELS);
    assign w_accept = (r_state == IDLE) && smp_valid && (prog_len != '0) && w_ch_ok;
    assign w_last   = ({1'b0, r_ip} == (r_len - prog_len_t'(1)));

    // Writes land only while idle. A write in the accepting IDLE cycle is
    // committed on the S1 entry edge, before the S1 read is clocked, so the
    // fetch sees the new word.
    assign w_mem_we = iw_en && (r_state == IDLE);
    // Reading during S1 loads the read register on the S1 exit edge; that
    // register holds the instruction fields for the rest of the instruction.
    assign w_mem_re = (r_state == S1);

    ctrl_sequencer_instr_mem u_instr_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_mem_we),
        .i_waddr (iw_addr),
        .i_wdata (iw_data),
        .i_re    (w_mem_re),
        .i_raddr (r_ip),
        .o_rdata (w_instr)
    );

    // -------------------------------------------------------------------------
    // State, instruction pointer and per-sample context
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ip       <= '0;
            r_len      <= '0;
            r_ch_off   <= '0;
            r_s3_entry <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_ip       <= w_next_ip;
            // Flags the single cycle in which S3 is first occupied.
            r_s3_entry <= (w_next_state == S3) && (r_state != S3);
            if (w_accept) begin
                r_len    <= clamp_prog_len(prog_len);
                // Channel buffer base; truncation to the RAM width is the
                // intended wrap-around.
                r_ch_off <= data_addr_t'(int'(smp_ch) * CH_STRIDE);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next state and state-decoded strobes
    // -------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_next_ip    = r_ip;
        mac_init     = 1'b0;
        rf_we        = 1'b0;
        rf_addr      = '0;
        out_valid    = 1'b0;
        smp_ready    = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = S1;
                    w_next_ip    = '0;
                end
            end
            S1: begin
                w_next_state = S2;
            end
            S2: begin
                mac_init     = 1'b1;
                w_next_state = S3;
            end
            S3: begin
                if (mac_done) begin
                    w_next_state = S4;
                end
            end
            S4: begin
                rf_we   = 1'b1;
                rf_addr = w_instr.result_reg;
                if (w_instr.error_reg != '0) begin
                    w_next_state = S5;
                end else if (w_instr.lstg_f) begin
                    w_next_state = S6;
                end else begin
                    w_next_state = S8;
                end
            end
            S5: begin
                rf_we        = 1'b1;
                rf_addr      = w_instr.error_reg;
                w_next_state = w_instr.lstg_f ? S6 : S8;
            end
            S6: begin
                out_valid    = 1'b1;
                w_next_state = S8;
            end
            S8: begin
                if (w_last) begin
                    w_next_state = S7;
                end else begin
                    w_next_ip    = r_ip + instr_pointer_t'(1);
                    w_next_state = S1;
                end
            end
            S7: begin
                smp_ready    = 1'b1;
                w_next_ip    = '0;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
                w_next_ip    = '0;
            end
        endcase
    end

    assign mac_start = r_s3_entry;
    assign state     = r_state;
    assign busy      = (r_state != IDLE);

    // Segment pointers are channel relative; the coefficient table is shared.
    assign data_uptr = w_instr.data_uptr + r_ch_off;
    assign data_lptr = w_instr.data_lptr + r_ch_off;
    assign coef_ptr  = w_instr.coef_ptr;
    assign vector_id = w_instr.vector_id;

endmodule

// File: tb/tb_ctrl_sequencer.sv
module tb_ctrl_sequencer;
    import ctrl_sequencer_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           iw_en = 1'b0;
    instr_pointer_t iw_addr = '0;
    allocInstr_s    iw_data = '0;
    prog_len_t      prog_len = '0;
    logic           smp_valid = 1'b0;
    ch_id_t         smp_ch = '0;
    logic           mac_done = 1'b0;
    logic           smp_ready, mac_init, mac_start, rf_we, out_valid, busy;
    reg_file_addr_t rf_addr;
    data_addr_t     data_uptr, data_lptr, coef_ptr;
    vector_id_t     vector_id;
    fsmState_e      state;

    always #5 clk = ~clk;

    ctrl_sequencer dut (
        .clk(clk), .rst_n(rst_n), .iw_en(iw_en), .iw_addr(iw_addr), .iw_data(iw_data),
        .prog_len(prog_len), .smp_valid(smp_valid), .smp_ch(smp_ch), .smp_ready(smp_ready),
        .mac_init(mac_init), .mac_start(mac_start), .mac_done(mac_done), .rf_we(rf_we),
        .rf_addr(rf_addr), .data_uptr(data_uptr), .data_lptr(data_lptr), .coef_ptr(coef_ptr),
        .vector_id(vector_id), .out_valid(out_valid), .state(state), .busy(busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: instruction memory image and per-sample expectations.
    allocInstr_s mdl [INSTRUCTION_MEMORY_SIZE];
    int          exp_cyc, exp_n, exp_ov;
    int          exp_rf[$];
    logic [63:0] exp_ptr[$];
    int          dly[$];

    // Monitor / MAC responder.
    int          cyc, n_init, n_start, n_ov, n_rdy;
    int          obs_rf[$];
    logic [63:0] obs_ptr[$];
    int          trace[$];
    int          dq[$];
    int          k_wait, d_cur;

    always @(negedge clk) begin
        if (state != IDLE) begin
            cyc++;
            trace.push_back(int'(state));
        end
        n_init  += int'(mac_init);
        n_start += int'(mac_start);
        n_ov    += int'(out_valid);
        n_rdy   += int'(smp_ready);
        if (rf_we) obs_rf.push_back(int'(rf_addr));
        if (mac_start) begin
            obs_ptr.push_back(64'({vector_id, coef_ptr, data_lptr, data_uptr}));
            k_wait = 0;
            d_cur  = (dq.size() > 0) ? dq.pop_front() : 0;
        end
        if (state == S3) begin
            mac_done = (k_wait >= d_cur);
            k_wait++;
        end else begin
            mac_done = 1'b0;
        end
    end

    function automatic allocInstr_s rnd_instr();
        allocInstr_s x;
        x.data_uptr  = data_addr_t'($urandom);
        x.data_lptr  = data_addr_t'($urandom);
        x.coef_ptr   = data_addr_t'($urandom);
        x.vector_id  = vector_id_t'($urandom);
        x.result_reg = reg_file_addr_t'($urandom);
        x.error_reg  = ($urandom_range(0, 1) == 1) ? reg_file_addr_t'($urandom_range(1, 31)) : '0;
        x.lstg_f     = 1'($urandom_range(0, 1));
        return x;
    endfunction

    function automatic allocInstr_s plain_instr(input int dl);
        allocInstr_s x;
        x = rnd_instr();
        x.data_lptr = data_addr_t'(dl);
        x.error_reg = '0;
        x.lstg_f    = 1'b0;
        return x;
    endfunction

    task automatic load(input int a, input allocInstr_s x);
        @(negedge clk);
        iw_en = 1'b1; iw_addr = instr_pointer_t'(a); iw_data = x;
        @(negedge clk);
        iw_en = 1'b0;
        mdl[a] = x;
    endtask

    task automatic clear_mon();
        cyc = 0; n_init = 0; n_start = 0; n_ov = 0; n_rdy = 0;
        obs_rf.delete(); obs_ptr.delete(); trace.delete();
    endtask

    task automatic start_sample(input int ch, input int plen, input bit wr, input int wa,
                                input allocInstr_s wd);
        int eff, d;
        clear_mon();
        dq = dly;
        @(negedge clk);
        prog_len = prog_len_t'(plen); smp_ch = ch_id_t'(ch); smp_valid = 1'b1;
        if (wr) begin
            iw_en = 1'b1; iw_addr = instr_pointer_t'(wa); iw_data = wd;
            mdl[wa] = wd;
        end
        @(negedge clk);
        smp_valid = 1'b0; iw_en = 1'b0;
        eff = (plen > INSTRUCTION_MEMORY_SIZE) ? INSTRUCTION_MEMORY_SIZE : plen;
        exp_n = eff; exp_cyc = 1; exp_ov = 0;
        exp_rf.delete(); exp_ptr.delete();
        for (int i = 0; i < eff; i++) begin
            d = (i < dly.size()) ? dly[i] : 0;
            exp_cyc += 5 + d + ((mdl[i].error_reg != 0) ? 1 : 0) + int'(mdl[i].lstg_f);
            exp_rf.push_back(int'(mdl[i].result_reg));
            if (mdl[i].error_reg != 0) exp_rf.push_back(int'(mdl[i].error_reg));
            exp_ov += int'(mdl[i].lstg_f);
            exp_ptr.push_back({24'd0, mdl[i].vector_id, mdl[i].coef_ptr,
                               12'((int'(mdl[i].data_lptr) + ch * CH_STRIDE) % 4096),
                               12'((int'(mdl[i].data_uptr) + ch * CH_STRIDE) % 4096)});
        end
    endtask

    task automatic finish_sample(input string tag);
        int t, bad;
        t = 0;
        while (state != IDLE && t < 5000) begin
            @(negedge clk);
            t++;
        end
        #1;
        if (t >= 5000) chk({tag, "_timeout"}, 64'(t), 64'd0);
        chk({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, "_mac_init"}, 64'(n_init), 64'(exp_n));
        chk({tag, "_mac_start"}, 64'(n_start), 64'(exp_n));
        chk({tag, "_out_valid"}, 64'(n_ov), 64'(exp_ov));
        chk({tag, "_smp_ready"}, 64'(n_rdy), 64'd1);
        chk({tag, "_rf_count"}, 64'(obs_rf.size()), 64'(exp_rf.size()));
        bad = 0;
        for (int i = 0; i < obs_rf.size() && i < exp_rf.size(); i++)
            if (obs_rf[i] != exp_rf[i]) bad++;
        chk({tag, "_rf_seq"}, 64'(bad), 64'd0);
        chk({tag, "_ptr_count"}, 64'(obs_ptr.size()), 64'(exp_ptr.size()));
        bad = 0;
        for (int i = 0; i < obs_ptr.size() && i < exp_ptr.size(); i++)
            if (obs_ptr[i] != exp_ptr[i]) bad++;
        chk({tag, "_ptrs"}, 64'(bad), 64'd0);
    endtask

    task automatic run(input string tag, input int ch, input int plen);
        allocInstr_s z;
        z = '0;
        start_sample(ch, plen, 1'b0, 0, z);
        finish_sample(tag);
    endtask

    function automatic logic [63:0] out_vec();
        return 64'({smp_ready, mac_init, mac_start, rf_we, out_valid, busy, rf_addr,
                    data_uptr, data_lptr, coef_ptr, vector_id});
    endfunction

    initial begin
        allocInstr_s x, alt, z;
        int bad, len, t;
        logic [63:0] pv;
        z = '0;

        // Reset
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state", 64'(state), 64'(IDLE));
        chk("rst_outputs", out_vec(), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_state", 64'(state), 64'(IDLE));

        for (int i = 0; i < INSTRUCTION_MEMORY_SIZE; i++) load(i, rnd_instr());

        // Three plain instructions, mac_done on S3 entry
        for (int i = 0; i < 3; i++) load(i, plain_instr(int'($urandom_range(0, 4095))));
        dly.delete();
        run("basic", 0, 3);
        bad = 0;
        if (trace.size() != 16) bad++;
        for (int i = 0; i < 15 && i < trace.size(); i++) begin
            case (i % 5)
                0: if (trace[i] != 1) bad++;
                1: if (trace[i] != 2) bad++;
                2: if (trace[i] != 3) bad++;
                3: if (trace[i] != 4) bad++;
                default: if (trace[i] != 8) bad++;
            endcase
        end
        if (trace.size() == 16 && trace[15] != 7) bad++;
        chk("basic_trace", 64'(bad), 64'd0);
        chk("basic_16cyc", 64'(cyc), 64'd16);

        // Error register and last stage on instruction 1
        x = mdl[1]; x.error_reg = 5'd7; x.lstg_f = 1'b1;
        load(1, x);
        run("err", 0, 3);
        chk("err_cycles18", 64'(cyc), 64'd18);
        chk("err_ov_once", 64'(n_ov), 64'd1);
        chk("err_rf_has7", 64'((obs_rf.size() > 2) ? obs_rf[2] : 0), 64'd7);

        // Channel offset with wrap
        x = plain_instr(12'hE00);
        load(0, x);
        run("chan", 1, 3);
        pv = (obs_ptr.size() > 0) ? obs_ptr[0] : 64'd0;
        chk("chan_lptr_wrap", 64'(pv[23:12]), 64'h200);
        chk("chan_coef", 64'(pv[35:24]), 64'(x.coef_ptr));

        // Long MAC wait
        dly = {10, 0, 0};
        run("wait", 0, 3);
        bad = 0;
        foreach (trace[i]) if (trace[i] == 3) bad++;
        chk("wait_s3_cycles", 64'(bad), 64'd13);
        dly.delete();

        // Write while busy is dropped; the same write in IDLE is applied
        alt = rnd_instr();
        start_sample(0, 3, 1'b0, 0, z);
        repeat (3) @(negedge clk);
        chk("busy_during", 64'(busy), 64'd1);
        iw_en = 1'b1; iw_addr = instr_pointer_t'(1); iw_data = alt;
        @(negedge clk);
        iw_en = 1'b0;
        finish_sample("busywr");
        run("after_busywr", 0, 3);
        start_sample(0, 3, 1'b1, 1, alt);
        finish_sample("idlewr");

        // Reset during S3 of instruction 2
        dly = {0, 0, 8};
        start_sample(1, 3, 1'b0, 0, z);
        t = 0;
        while (n_start < 3 && t < 200) begin
            @(negedge clk); #1; t++;
        end
        chk("abort_reach_s3", 64'(state), 64'(S3));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_state", 64'(state), 64'(IDLE));
        chk("abort_outputs", out_vec(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("abort_no_ready", 64'(n_rdy), 64'd0);
        dly.delete();
        run("restart", 0, 3);

        // Program disabled
        clear_mon();
        @(negedge clk);
        prog_len = '0; smp_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (state != IDLE) bad++;
        end
        smp_valid = 1'b0;
        #1;
        chk("len0_idle", 64'(bad), 64'd0);
        chk("len0_no_ready", 64'(n_rdy), 64'd0);

        // Length above memory depth is clamped
        run("clamp", 0, 40);

        // Randomised samples
        for (int it = 0; it < 20; it++) begin
            len = int'($urandom_range(1, 8));
            for (int i = 0; i < len; i++) load(i, rnd_instr());
            dly.delete();
            for (int i = 0; i < len; i++) dly.push_back(int'($urandom_range(0, 3)));
            run("rnd", int'($urandom_range(0, NUM_CHANNELS - 1)), len);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Parametrised, multi-channel successor to the fixed single-channel control plan.
- Holds a loadable allocation-instruction memory and walks every instruction through the allocation/convolution state sequence once per input sample.
- Issues pulses to the data RAM, the MAC and the register file.
- Sits between the audio input bus and the datapath (RAM, MAC, register file) of the sample rate converter.

Parameters:
VECTOR_ID_WIDTH, 4, vector ID field width
REG_FILE_ADDRESS_WIDTH, 5, register file address width
DATA_RAM_ADDRESS_WIDTH, 12, data/coef RAM address width
INSTRUCTION_MEMORY_SIZE, 32, instruction memory depth (power of 2)
NUM_CHANNELS, 2, audio channels sharing one program
CH_STRIDE, 1024, data RAM offset between channel buffers

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
iw_en  in  1  instruction memory write strobe (honoured only when busy=0)
iw_addr  in  $clog2(INSTRUCTION_MEMORY_SIZE)  write address
iw_data  in  allocInstr_s  instruction word
prog_len  in  $clog2(INSTRUCTION_MEMORY_SIZE)+1  instruction count; 0 = program disabled
smp_valid  in  1  new sample available on audio bus
smp_ch  in  $clog2(NUM_CHANNELS)  channel of offered sample
smp_ready  out  1  sample accepted (pulse, S7)
mac_init  out  1  pulse in S2
mac_start  out  1  pulse on S3 entry
mac_done  in  1  MAC finished convolution
rf_we  out  1  register file write (S4/S5)
rf_addr  out  REG_FILE_ADDRESS_WIDTH  result_reg in S4, error_reg in S5
data_uptr, data_lptr  out  DATA_RAM_ADDRESS_WIDTH  channel-offset segment pointers
coef_ptr  out  DATA_RAM_ADDRESS_WIDTH  coefficient pointer (not offset)
vector_id  out  VECTOR_ID_WIDTH  current vector ID
out_valid  out  1  system output sample strobe (S6)
state  out  fsmState_e  current state
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ip=0, all pulses 0, all pointers/IDs 0. Instruction memory contents are not reset.
- State enum widens to 4 bits: IDLE plus S1..S8 with the existing meanings.
- IDLE:
  - If smp_valid and prog_len!=0: latch smp_ch, set ip=0, go to S1.
  - If smp_ch >= NUM_CHANNELS: ignore the sample and stay in IDLE.
- S1 (allocation):
  - Registered memory read of instr[ip], 1 cycle latency; fields latched on S1 exit.
  - data_uptr and data_lptr = field + ch*CH_STRIDE, truncated mod 2^DATA_RAM_ADDRESS_WIDTH (wrap allowed).
  - Go to S2.
- S2: mac_init=1 for one cycle; go to S3.
- S3: mac_start=1 on the entry cycle only. Stay until mac_done=1; then go to S4. mac_done in the entry cycle counts.
- S4: rf_we=1, rf_addr=result_reg.
  - Go to S5 if error_reg!=0.
  - Else go to S6 if lstg_f.
  - Else go to S8.
- S5: rf_we=1, rf_addr=error_reg. Go to S6 if lstg_f, else S8.
- S6: out_valid=1 for one cycle; go to S8.
- S8 (allocation list counter increment):
  - If ip==prog_len-1: go to S7.
  - Else ip++ and go to S1.
- S7: smp_ready=1 for one cycle; ip=0; go to IDLE.
- The next sample can be accepted one cycle after S7, i.e. back-to-back samples are separated by one IDLE cycle.
- iw_en while busy=1: write is dropped.
- iw_en and a sample start in the same IDLE cycle: the write completes first, and the S1 read sees the new data.
- prog_len > INSTRUCTION_MEMORY_SIZE: clamp to INSTRUCTION_MEMORY_SIZE.
- Minimum per-instruction latency: S1,S2,S3,S4,S8 = 5 cycles with mac_done in the S3 entry cycle.
- Reset mid-operation: abort immediately, with no smp_ready and no partial pulses after rst_n deasserts.

Decomposition:
- Package ctrl gains:
  - fsmState_e widened to 4 bits with IDLE.
  - Parametrised allocInstr_s field widths.
  - A ch_id_t typedef.
  - CH_STRIDE default.
- Existing typedefs (data_addr_t, reg_file_addr_t, vector_id_t, instr_pointer_t) are reused unchanged.
- One sub-module, ctrl_instr_mem: 1 write port, 1 registered read port, no reset on the array.

Test Plan:
- Reset, then load 3 instructions (prog_len=3, lstg_f=0 on all, error_reg=0), smp_valid ch0, mac_done in the S3 entry cycle -> state trace S1,S2,S3,S4,S8 ×3, then S7; smp_ready once; total 16 cycles from acceptance to IDLE.
- Same program but instr1 has error_reg=7 and lstg_f=1 -> S5 with rf_addr=7 and rf_we, then S6 with one out_valid pulse; no extra pulses elsewhere.
- Channel offset: ch1, data_lptr=0xE00, CH_STRIDE=1024 -> data_lptr out = 0x200 (wrap); coef_ptr unchanged.
- mac_done held low for 10 cycles in S3 -> state stays S3; mac_start high on the first cycle only.
- iw_en to addr 1 while busy -> instr1 unchanged on the next sample; the same write issued in IDLE is applied.
- rst_n low during S3 of instr 2 -> async return to IDLE with all outputs 0; the next sample restarts at ip=0; prog_len=0 -> smp_valid ignored, smp_ready never asserted.
